// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pipe
// Purpose  : Registered MIPS ALU-control stage. Decodes opcode + funct into
//            an ALU operation code, an ALUSrc select and an illegal flag.
//            Valid/ready handshake on both sides. A new MULT/DIV is held off
//            while the multi-cycle mult/div unit is still busy.
// Options  : ALU_STATS_EN - adds saturating instruction / illegal counters
//            (stat_insn, stat_illegal).
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe #(
    parameter int ALUOP_W    = 4,
    parameter int MULDIV_LAT = 8,
    parameter int STAT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_op,
    input  logic [5:0]         in_funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_alusrc,
    output logic               out_illegal,
    output logic               md_busy
`ifdef ALU_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_insn,
    output logic [STAT_W-1:0]  stat_illegal
`endif
);

    // ALU operation codes
    localparam logic [3:0] c_AND  = 4'd0;
    localparam logic [3:0] c_OR   = 4'd1;
    localparam logic [3:0] c_ADD  = 4'd2;
    localparam logic [3:0] c_XOR  = 4'd3;
    localparam logic [3:0] c_NOR  = 4'd4;
    localparam logic [3:0] c_SLL  = 4'd5;
    localparam logic [3:0] c_SUB  = 4'd6;
    localparam logic [3:0] c_SLT  = 4'd7;
    localparam logic [3:0] c_SLTU = 4'd8;
    localparam logic [3:0] c_SRL  = 4'd9;
    localparam logic [3:0] c_SRA  = 4'd10;
    localparam logic [3:0] c_LUI  = 4'd11;
    localparam logic [3:0] c_MULT = 4'd12;
    localparam logic [3:0] c_DIV  = 4'd13;

    localparam int                 c_CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MULDIV_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Parameter sanity checks at elaboration
    if (ALUOP_W < 4) begin : g_chk_aluop_w
        $error("alu_ctrl_pipe: ALUOP_W must be >= 4");
    end
    if (MULDIV_LAT < 1) begin : g_chk_lat
        $error("alu_ctrl_pipe: MULDIV_LAT must be >= 1");
    end
    if (STAT_W < 1) begin : g_chk_stat_w
        $error("alu_ctrl_pipe: STAT_W must be >= 1");
    end

    logic [3:0]         w_aluop;
    logic               w_alusrc;
    logic               w_illegal;
    logic               w_md_req;
    logic               w_md_block;
    logic               w_in_ready;
    logic               w_in_hs;
    logic               w_out_hs;

    logic               r_out_valid;
    logic [3:0]         r_aluop;
    logic               r_alusrc;
    logic               r_illegal;
    logic               r_out_md;
    logic [c_CNT_W-1:0] r_cnt;

    // Combinational decode of opcode / funct; unknown encodings flag illegal
    always_comb begin
        w_aluop   = c_AND;
        w_alusrc  = 1'b0;
        w_illegal = 1'b0;
        case (in_op)
            6'h00: begin
                case (in_funct)
                    6'h20, 6'h21: w_aluop = c_ADD;
                    6'h22, 6'h23: w_aluop = c_SUB;
                    6'h24:        w_aluop = c_AND;
                    6'h25:        w_aluop = c_OR;
                    6'h26:        w_aluop = c_XOR;
                    6'h27:        w_aluop = c_NOR;
                    6'h2A:        w_aluop = c_SLT;
                    6'h2B:        w_aluop = c_SLTU;
                    6'h00:        w_aluop = c_SLL;
                    6'h02:        w_aluop = c_SRL;
                    6'h03:        w_aluop = c_SRA;
                    6'h18, 6'h19: w_aluop = c_MULT;
                    6'h1A, 6'h1B: w_aluop = c_DIV;
                    default:      w_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin w_aluop = c_ADD;  w_alusrc = 1'b1; end
            6'h0A:                      begin w_aluop = c_SLT;  w_alusrc = 1'b1; end
            6'h0B:                      begin w_aluop = c_SLTU; w_alusrc = 1'b1; end
            6'h0C:                      begin w_aluop = c_AND;  w_alusrc = 1'b1; end
            6'h0D:                      begin w_aluop = c_OR;   w_alusrc = 1'b1; end
            6'h0E:                      begin w_aluop = c_XOR;  w_alusrc = 1'b1; end
            6'h0F:                      begin w_aluop = c_LUI;  w_alusrc = 1'b1; end
            6'h04, 6'h05:               w_aluop = c_SUB;
            default:                    w_illegal = 1'b1;
        endcase
    end

    // A mult/div must wait while the unit runs or while one still sits in the output stage
    assign w_md_req   = (w_aluop == c_MULT) || (w_aluop == c_DIV);
    assign w_md_block = md_busy || (r_out_valid && r_out_md);
    assign w_in_ready = !flush && (!r_out_valid || out_ready) && !(w_md_req && w_md_block);
    assign w_in_hs    = in_valid && w_in_ready;
    // An output transfer completes even when flush is asserted in the same cycle
    assign w_out_hs   = r_out_valid && out_ready;

    // Output stage register: load on accept, drop on drain, kill on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_aluop     <= 4'd0;
            r_alusrc    <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_md    <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_in_hs) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_hs) begin
                r_aluop   <= w_aluop;
                r_alusrc  <= w_alusrc;
                r_illegal <= w_illegal;
                r_out_md  <= w_md_req;
            end
        end
    end

    // Mult/div busy counter: loads when a MULT/DIV leaves, then counts down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_out_hs && r_out_md) begin
            r_cnt <= c_LAT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    // Zero-extend the 4-bit code to the configured output width
    always_comb begin
        out_aluop      = '0;
        out_aluop[3:0] = r_aluop;
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_alusrc  = r_alusrc;
    assign out_illegal = r_illegal;
    assign md_busy     = (r_cnt != '0);

`ifdef ALU_STATS_EN
    localparam logic [STAT_W-1:0] c_STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] r_stat_insn;
    logic [STAT_W-1:0] r_stat_illegal;

    // Saturating counters of delivered instructions and delivered illegal ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_insn    <= '0;
            r_stat_illegal <= '0;
        end else if (w_out_hs) begin
            if (r_stat_insn != '1) begin
                r_stat_insn <= r_stat_insn + c_STAT_ONE;
            end
            if (r_illegal && (r_stat_illegal != '1)) begin
                r_stat_illegal <= r_stat_illegal + c_STAT_ONE;
            end
        end
    end

    assign stat_insn    = r_stat_insn;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Registered, parametrised ALU control stage for the MIPS core. It decodes opcode plus funct into an ALU operation code, an ALUSrc select and an illegal-instruction flag, and covers both R-type and I-type instructions. Sits between the ID stage and the EX stage, with a valid/ready handshake on each side. Holds back a new mult/div while the multi-cycle mult/div unit is still busy.

Parameters:
ALUOP_W, 4, width of out_aluop; must be >= 4; bits above [3] are driven 0
MULDIV_LAT, 8, busy cycles after a mult/div leaves the output stage; must be >= 1
STAT_W, 16, width of the statistics counters (used only with ALU_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the output stage
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
in_op  in  6  opcode [31:26]
in_funct  in  6  funct [5:0]
out_valid  out  1  decoded result present
out_ready  in  1  EX accepts the result
out_aluop  out  ALUOP_W  ALU operation code
out_alusrc  out  1  1 = immediate operand
out_illegal  out  1  unrecognised op/funct
md_busy  out  1  mult/div unit occupied

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_aluop=0, out_alusrc=0, out_illegal=0, md_busy=0, busy counter=0.
- ALU codes: AND=0, OR=1, ADD=2, XOR=3, NOR=4, SLL=5, SUB=6, SLT=7, SLTU=8, SRL=9, SRA=10, LUI=11, MULT=12, DIV=13.
- R-type decode (op=0x00, alusrc=0), by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - 0x18/0x19 MULT; 0x1A/0x1B DIV.
- I-type decode:
  - alusrc=1: 0x08/0x09 ADD; 0x0A SLT; 0x0B SLTU; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0F LUI; 0x23/0x2B ADD.
  - alusrc=0: 0x04/0x05 SUB.
- Any other op/funct: aluop=0, alusrc=0, illegal=1. It still flows through the handshake.
- Latency: exactly 1 cycle, from input handshake to out_valid.
- in_ready = !flush && (!out_valid || out_ready) && !(md_req && md_block).
  - md_req: the input decodes to MULT or DIV.
  - md_block: md_busy=1, or the output stage holds a MULT/DIV.
- Output holds stable while out_valid && !out_ready. No bubble under continuous flow (full throughput).
- Busy counter:
  - Loaded with MULDIV_LAT when a MULT/DIV output handshake occurs; decrements each cycle while nonzero.
  - md_busy = (counter != 0).
  - A new mult/div is accepted no earlier than the cycle the counter reaches 0.
  - Non-md instructions are never blocked by md_busy.
- flush=1: next cycle out_valid=0, regardless of out_ready; the input is not accepted that cycle. The busy counter is unaffected, because the unit is already running.
- Output handshake with flush in the same cycle: the transfer completes and the counter loads as normal.
- Reset mid-operation: all state clears immediately, including a running busy count.

Optional Feature:
ALU_STATS_EN.
- Defined: adds outputs stat_insn[STAT_W] and stat_illegal[STAT_W].
  - Both increment on each output handshake; stat_illegal only when out_illegal=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent. Decode and handshake behaviour are identical.

Test Plan:
- Reset then op=0x00 funct=0x20, in_valid=1, out_ready=1 -> next cycle out_valid=1, aluop=2, alusrc=0, illegal=0.
- Back-to-back op=0x0D, 0x0F, 0x04 with out_ready=1 -> consecutive cycles show aluop 1/alusrc 1, 11/1, 6/0; in_ready stays 1.
- op=0x3F -> aluop=0, illegal=1. out_ready=0 for 3 cycles -> output held; in_ready=0; nothing lost.
- MULT (funct 0x18) accepted, then DIV presented, MULDIV_LAT=8 -> md_busy high 8 cycles after the MULT handshake; DIV in_ready=0 until the counter hits 0; an ADD in between passes.
- Output valid with flush=1, out_ready=0 -> out_valid=0 next cycle; in_ready=0 during the flush cycle.
- rst_n pulsed low mid-busy (counter=5) -> md_busy=0 and out_valid=0 immediately; with ALU_STATS_EN, counters=0.
